// File: rtl/cache_mem_arbiter.sv
// cache_mem_arbiter: shares one SRAM-like memory port between the i_cache
// and d_cache miss paths. One transaction is in flight at a time. Request
// fields are latched at grant, and the response is steered back to the owner.
module cache_mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int D_PRIORITY = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_req,
  input  logic [1:0]            i_size,
  input  logic [ADDR_WIDTH-1:0] i_addr,
  output logic                  i_addr_ok,
  output logic                  i_data_ok,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_wr,
  input  logic [1:0]            d_size,
  input  logic [ADDR_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  input  logic [3:0]            d_wstrb,
  output logic                  d_addr_ok,
  output logic                  d_data_ok,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  mem_req,
  output logic                  mem_wr,
  output logic [1:0]            mem_size,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic [3:0]            mem_wstrb,
  input  logic                  mem_addr_ok,
  input  logic                  mem_data_ok,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  output logic                  busy
);

  typedef enum logic [1:0] {IDLE = 2'd0, ADDR = 2'd1, DATA = 2'd2} state_t;

  state_t                  state, state_nxt;
  logic                    owner_d;     // 1 = data side owns the transaction
  logic                    last_d;      // 1 = data side won the last grant
  logic                    gnt_i, gnt_d;
  logic                    done;
  logic                    cap_wr;
  logic [1:0]              cap_size;
  logic [ADDR_WIDTH-1:0]   cap_addr;
  logic [DATA_WIDTH-1:0]   cap_wdata;
  logic [3:0]              cap_wstrb;

  // Grant decision in IDLE. On a conflict the data side wins under fixed
  // priority; otherwise the side that did not win last time gets the grant.
  // Grants are suppressed while reset is held so the accept pulses stay low.
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    if (state == IDLE && !rst) begin
      gnt_d = d_req && (!i_req || (D_PRIORITY != 0) || !last_d);
      gnt_i = i_req && !gnt_d;
    end
  end

  // Completion: a normal data phase, or address and data accepted together.
  always_comb begin
    done = !rst && (((state == DATA) && mem_data_ok) ||
                    ((state == ADDR) && mem_addr_ok && mem_data_ok));
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state logic.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (gnt_i || gnt_d) state_nxt = ADDR;
      ADDR:    if (mem_addr_ok)    state_nxt = mem_data_ok ? IDLE : DATA;
      DATA:    if (mem_data_ok)    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Owner, round-robin history and the captured request fields, updated at grant.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      owner_d   <= 1'b0;
      last_d    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_size  <= 2'd0;
      cap_addr  <= '0;
      cap_wdata <= '0;
      cap_wstrb <= 4'd0;
    end else if (gnt_d) begin
      owner_d   <= 1'b1;
      last_d    <= 1'b1;
      cap_wr    <= d_wr;
      cap_size  <= d_size;
      cap_addr  <= d_addr;
      cap_wdata <= d_wdata;
      cap_wstrb <= d_wstrb;
    end else if (gnt_i) begin
      owner_d   <= 1'b0;
      last_d    <= 1'b0;
      cap_wr    <= 1'b0;
      cap_size  <= i_size;
      cap_addr  <= i_addr;
      cap_wdata <= '0;
      cap_wstrb <= 4'd0;
    end
  end

  // Output decode: the accept and completion pulses, read data steering and the memory side.
  always_comb begin
    i_addr_ok = gnt_i;
    d_addr_ok = gnt_d;
    i_data_ok = done && !owner_d;
    d_data_ok = done && owner_d;
    i_rdata   = i_data_ok ? mem_rdata : '0;
    d_rdata   = d_data_ok ? mem_rdata : '0;
    mem_req   = (state == ADDR);
    mem_wr    = cap_wr;
    mem_size  = cap_size;
    mem_addr  = cap_addr;
    mem_wdata = cap_wdata;
    mem_wstrb = cap_wstrb;
    busy      = (state != IDLE);
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Bench for cache_mem_arbiter: two instances (round-robin and data priority)
// share every input, and a scoreboard holds the expected responses.
module tb_cache_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct packed {
    logic          is_d;
    logic [DW-1:0] rdata;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic          i_req, d_req, d_wr, mem_addr_ok, mem_data_ok;
  logic [1:0]    i_size, d_size;
  logic [AW-1:0] i_addr, d_addr;
  logic [DW-1:0] d_wdata, mem_rdata;
  logic [3:0]    d_wstrb;

  logic          i_addr_ok_o [2], i_data_ok_o [2], d_addr_ok_o [2], d_data_ok_o [2];
  logic          mem_req_o [2], mem_wr_o [2], busy_o [2];
  logic [DW-1:0] i_rdata_o [2], d_rdata_o [2], mem_wdata_o [2];
  logic [1:0]    mem_size_o [2];
  logic [AW-1:0] mem_addr_o [2];
  logic [3:0]    mem_wstrb_o [2];

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .D_PRIORITY(0)) dut0 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_size(i_size), .i_addr(i_addr),
    .i_addr_ok(i_addr_ok_o[0]), .i_data_ok(i_data_ok_o[0]), .i_rdata(i_rdata_o[0]),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_addr_ok(d_addr_ok_o[0]), .d_data_ok(d_data_ok_o[0]), .d_rdata(d_rdata_o[0]),
    .mem_req(mem_req_o[0]), .mem_wr(mem_wr_o[0]), .mem_size(mem_size_o[0]),
    .mem_addr(mem_addr_o[0]), .mem_wdata(mem_wdata_o[0]), .mem_wstrb(mem_wstrb_o[0]),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy_o[0])
  );

  cache_mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .D_PRIORITY(1)) dut1 (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_size(i_size), .i_addr(i_addr),
    .i_addr_ok(i_addr_ok_o[1]), .i_data_ok(i_data_ok_o[1]), .i_rdata(i_rdata_o[1]),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr),
    .d_wdata(d_wdata), .d_wstrb(d_wstrb),
    .d_addr_ok(d_addr_ok_o[1]), .d_data_ok(d_data_ok_o[1]), .d_rdata(d_rdata_o[1]),
    .mem_req(mem_req_o[1]), .mem_wr(mem_wr_o[1]), .mem_size(mem_size_o[1]),
    .mem_addr(mem_addr_o[1]), .mem_wdata(mem_wdata_o[1]), .mem_wstrb(mem_wstrb_o[1]),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy_o[1])
  );

  int   errors = 0;
  int   checks = 0;
  exp_t sb0 [$];
  exp_t sb1 [$];

  task automatic chk(input string tag, input int k, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s[dut%0d] observed=0x%0h expected=0x%0h", tag, k, obs, exp);
    end
  endtask

  task automatic chk_all_zero(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_ok"}, k, {60'd0, i_addr_ok_o[k], i_data_ok_o[k], d_addr_ok_o[k], d_data_ok_o[k]}, 64'd0);
      chk({tag, "_rdata"}, k, {i_rdata_o[k], d_rdata_o[k]}, 64'd0);
      chk({tag, "_memctl"}, k, {56'd0, mem_req_o[k], mem_wr_o[k], mem_size_o[k], mem_wstrb_o[k]}, 64'd0);
      chk({tag, "_memad"}, k, {mem_addr_o[k], mem_wdata_o[k]}, 64'd0);
      chk({tag, "_busy"}, k, {63'd0, busy_o[k]}, 64'd0);
    end
  endtask

  // Expect the grant this cycle; record the response each instance owes.
  task automatic expect_grant(input logic e0, input logic e1, input logic [DW-1:0] rd);
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      e.is_d  = (k == 0) ? e0 : e1;
      e.rdata = rd;
      chk("i_addr_ok", k, {63'd0, i_addr_ok_o[k]}, {63'd0, !e.is_d});
      chk("d_addr_ok", k, {63'd0, d_addr_ok_o[k]}, {63'd0, e.is_d});
      chk("busy_idle", k, {63'd0, busy_o[k]}, 64'd0);
      if (k == 0) sb0.push_back(e);
      else        sb1.push_back(e);
    end
  endtask

  task automatic check_mem(input int k, input logic is_d);
    logic [AW-1:0] ea;
    logic [DW-1:0] ewd;
    logic [3:0]    ews;
    logic [1:0]    esz;
    logic          ewr;
    ea  = is_d ? d_addr : i_addr;
    ewd = is_d ? d_wdata : '0;
    ews = is_d ? d_wstrb : 4'd0;
    esz = is_d ? d_size : i_size;
    ewr = is_d ? d_wr : 1'b0;
    chk("mem_req", k, {63'd0, mem_req_o[k]}, 64'd1);
    chk("mem_addr", k, {32'd0, mem_addr_o[k]}, {32'd0, ea});
    chk("mem_wdata", k, {32'd0, mem_wdata_o[k]}, {32'd0, ewd});
    chk("mem_ctl", k, {57'd0, mem_wr_o[k], mem_size_o[k], mem_wstrb_o[k]}, {57'd0, ewr, esz, ews});
  endtask

  task automatic chk_no_done(input string tag);
    for (int k = 0; k < 2; k++) begin
      chk({tag, "_data_ok"}, k, {62'd0, i_data_ok_o[k], d_data_ok_o[k]}, 64'd0);
      chk({tag, "_rdata"}, k, {i_rdata_o[k], d_rdata_o[k]}, 64'd0);
    end
  endtask

  // Compare both instances' completion against the oldest scoreboard entry.
  task automatic check_done();
    exp_t e;
    for (int k = 0; k < 2; k++) begin
      chk("sb_pending", k, {63'd0, ((k == 0) ? sb0.size() : sb1.size()) > 0}, 64'd1);
      e = '0;
      if (k == 0 && sb0.size() > 0) e = sb0.pop_front();
      if (k == 1 && sb1.size() > 0) e = sb1.pop_front();
      chk("data_ok", k, {62'd0, i_data_ok_o[k], d_data_ok_o[k]}, {62'd0, !e.is_d, e.is_d});
      chk("rdata", k, {i_rdata_o[k], d_rdata_o[k]},
          e.is_d ? {32'd0, e.rdata} : {e.rdata, 32'd0});
    end
  endtask

  // One transaction starting in an IDLE cycle with requests already driven.
  task automatic run_xact(input logic e0, input logic e1, input int alat, input int dlat,
                          input logic [DW-1:0] rd, input logic same, input logic drop);
    @(negedge clk);
    expect_grant(e0, e1, rd);
    @(posedge clk); #1;
    if (drop) begin i_req = 1'b0; d_req = 1'b0; end
    mem_rdata = 32'hA5A5A5A5;
    for (int c = 0; c < alat; c++) begin
      @(negedge clk);
      check_mem(0, e0);
      check_mem(1, e1);
      chk_no_done("addr_wait");
      @(posedge clk); #1;
    end
    mem_addr_ok = 1'b1;
    if (same) begin mem_data_ok = 1'b1; mem_rdata = rd; end
    @(negedge clk);
    check_mem(0, e0);
    check_mem(1, e1);
    if (same) check_done();
    else      chk_no_done("addr_acc");
    @(posedge clk); #1;
    mem_addr_ok = 1'b0;
    mem_data_ok = 1'b0;
    mem_rdata   = 32'h5A5A5A5A;
    if (!same) begin
      for (int c = 0; c < dlat; c++) begin
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
          chk("data_mem_req", k, {63'd0, mem_req_o[k]}, 64'd0);
          chk("data_busy", k, {63'd0, busy_o[k]}, 64'd1);
        end
        chk_no_done("data_wait");
        @(posedge clk); #1;
      end
      mem_data_ok = 1'b1;
      mem_rdata   = rd;
      @(negedge clk);
      check_done();
      @(posedge clk); #1;
      mem_data_ok = 1'b0;
      mem_rdata   = '0;
    end
  endtask

  initial begin
    rst = 1'b1;
    i_req = 0; i_size = 0; i_addr = '0;
    d_req = 0; d_wr = 0; d_size = 0; d_addr = '0; d_wdata = '0; d_wstrb = '0;
    mem_addr_ok = 0; mem_data_ok = 0; mem_rdata = '0;
    #12;
    chk_all_zero("reset");
    @(posedge clk); #1;
    rst = 1'b0;

    // I-only read: addr_ok after two wait cycles, data_ok after two more.
    i_req = 1'b1; i_size = 2'd2; i_addr = 32'hBFC00000;
    run_xact(1'b0, 1'b0, 2, 2, 32'h3C080001, 1'b0, 1'b1);

    // D-only write.
    d_req = 1'b1; d_wr = 1'b1; d_size = 2'd2; d_addr = 32'h80001000;
    d_wdata = 32'hDEADBEEF; d_wstrb = 4'hF;
    run_xact(1'b1, 1'b1, 1, 1, 32'h00000000, 1'b0, 1'b1);

    // Fresh reset so round-robin history starts at I, then four held conflicts.
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1; rst = 1'b0;
    i_req = 1'b1; i_addr = 32'hBFC00040; i_size = 2'd2;
    d_req = 1'b1; d_wr = 1'b0; d_addr = 32'h80002000; d_size = 2'd1;
    d_wdata = 32'h12345678; d_wstrb = 4'h3;
    run_xact(1'b1, 1'b1, 0, 1, 32'h11111111, 1'b0, 1'b0);
    run_xact(1'b0, 1'b1, 1, 0, 32'h22222222, 1'b0, 1'b0);
    run_xact(1'b1, 1'b1, 0, 0, 32'h33333333, 1'b0, 1'b0);
    run_xact(1'b0, 1'b1, 2, 1, 32'h44444444, 1'b0, 1'b1);

    // Address and data accepted in the same cycle, then idle.
    i_req = 1'b1; i_addr = 32'hBFC00080; i_size = 2'd0;
    run_xact(1'b0, 1'b0, 0, 0, 32'hCAFEF00D, 1'b1, 1'b1);
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("busy_after_same", k, {63'd0, busy_o[k]}, 64'd0);
    @(posedge clk); #1;

    // Reset during the data phase, then a stale response after release.
    d_req = 1'b1; d_wr = 1'b1; d_addr = 32'h80003000; d_wdata = 32'h0BADF00D; d_wstrb = 4'hC;
    @(negedge clk);
    expect_grant(1'b1, 1'b1, 32'h0);
    @(posedge clk); #1;
    d_req = 1'b0;
    mem_addr_ok = 1'b1;
    @(posedge clk); #1;
    mem_addr_ok = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("busy_data", k, {63'd0, busy_o[k]}, 64'd1);
    rst = 1'b1; i_req = 1'b1; mem_rdata = 32'h77777777;
    #1;
    chk_all_zero("async_rst");
    sb0.delete();
    sb1.delete();
    @(posedge clk); #1;
    i_req = 1'b0; rst = 1'b0;
    mem_data_ok = 1'b1;
    @(negedge clk);
    chk_no_done("stale");
    for (int k = 0; k < 2; k++) chk("stale_busy", k, {63'd0, busy_o[k]}, 64'd0);
    @(posedge clk); #1;
    mem_data_ok = 1'b0;
    @(negedge clk);
    for (int k = 0; k < 2; k++) chk("stale_idle", k, {63'd0, busy_o[k]}, 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end
endmodule
